mux_sel_reg_nto1: RTL

//   Parametrised N-input, W-bit result selector with a registered output stage and

---
 rtl/mux_sel_reg_nto1.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mux_sel_reg_nto1.sv
// mux_sel_reg_nto1: N-input, W-bit result selector with a registered output stage,
//   a valid/ready handshake and a one-entry skid buffer. Out-of-range selects produce
//   zero data plus an error flag and bump a saturating error counter.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle throughput.
// Backpressure: a beat accepted while the output stalls parks in the skid; in_ready
//   is derived from skid state only (no path from out_ready).
// Optional feature macro: MUX_FLAGS_EN adds out_zero / out_neg result flags.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_data, in_sel           packed inputs (input k = in_data[k*W +: W]) and select
//   in_valid, in_ready        upstream handshake
//   out_data, out_sel_err     registered selected data and out-of-range flag
//   out_valid, out_ready      downstream handshake
//   err_cnt                   saturating count of accepted out-of-range beats
//   out_zero, out_neg         (MUX_FLAGS_EN only) out_data == 0, out_data sign bit

module mux_sel_reg_nto1 #(
  parameter int N    = 6,
  parameter int W    = 16,
  parameter int CNTW = 8,
  localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [SELW-1:0] in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_sel_err,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef MUX_FLAGS_EN
  output logic            out_zero,
  output logic            out_neg,
`endif
  output logic [CNTW-1:0] err_cnt
);

  // Selection-time results for the beat currently presented
  logic [W-1:0] sel_data;
  logic         sel_err;
  logic         accept;

  // Skid buffer
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         skid_err;

`ifdef MUX_FLAGS_EN
  logic sel_zero;
  logic sel_neg;
  logic skid_zero;
  logic skid_neg;
`endif

  // Ready depends only on skid occupancy; rst gating keeps it low throughout reset
  // and lets it rise on the first cycle after release.
  assign in_ready = !skid_valid && !rst;
  assign accept   = in_valid && in_ready;

  // Loop-compare mux so an out-of-range select never indexes past in_data.
  always_comb begin
    sel_data = '0;
    sel_err  = (32'(in_sel) >= N);
    for (int k = 0; k < N; k++) begin
      if (32'(in_sel) == k) begin
        sel_data = in_data[k*W +: W];
      end
    end
  end

`ifdef MUX_FLAGS_EN
  // Out-of-range beats carry zero data, so they naturally give zero=1, neg=0.
  assign sel_zero = (sel_data == '0);
  assign sel_neg  = sel_data[W-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sel_err <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
      err_cnt     <= '0;
`ifdef MUX_FLAGS_EN
      out_zero    <= 1'b0;
      out_neg     <= 1'b0;
      skid_zero   <= 1'b0;
      skid_neg    <= 1'b0;
`endif
    end else begin
      // Counted at acceptance, saturating at all-ones.
      if (accept && sel_err && (err_cnt != {CNTW{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end

      if (out_valid && !out_ready) begin
        // Stall: output holds; a newly accepted beat parks in the skid.
        if (accept) begin
          skid_valid <= 1'b1;
          skid_data  <= sel_data;
          skid_err   <= sel_err;
`ifdef MUX_FLAGS_EN
          skid_zero  <= sel_zero;
          skid_neg   <= sel_neg;
`endif
        end
      end else if (skid_valid) begin
        // Drain the skid first; in_ready is low so nothing is accepted this cycle.
        out_valid   <= 1'b1;
        out_data    <= skid_data;
        out_sel_err <= skid_err;
        skid_valid  <= 1'b0;
`ifdef MUX_FLAGS_EN
        out_zero    <= skid_zero;
        out_neg     <= skid_neg;
`endif
      end else begin
        out_valid <= accept;
        // Data only loads on a transfer so an idle output keeps its last value.
        if (accept) begin
          out_data    <= sel_data;
          out_sel_err <= sel_err;
`ifdef MUX_FLAGS_EN
          out_zero    <= sel_zero;
          out_neg     <= sel_neg;
`endif
        end
      end
    end
  end

endmodule
